stack_sequencer: RTL and testbench

- Program sequencer for the nibble-serial stack CPU.
- Holds a small loadable program memory of 4-bit nibbles and replays it into the CPU's 4-bit instruction/operand input. It stays cycle-locked to the CPU's fetch/execute rhythm.
- Owns the CPU reset and supports free-run and single-step modes.
- Emits NOOP padding whenever no program instruction is being issued.

---
 rtl/stack_sequencer_pkg.sv | 43 ++++
 rtl/seq_program_mem.sv | 29 ++
 rtl/stack_sequencer.sv | 150 +++++++++++++++
 tb/tb_stack_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_sequencer_pkg.sv
// Shared opcode values, opcode-class helpers and state encoding for the
// nibble-serial stack CPU program sequencer.
package stack_sequencer_pkg;

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_OUTL = 4'h3;
  localparam logic [3:0] OP_OUTH = 4'h4;
  localparam logic [3:0] OP_SWAP = 4'h5;
  localparam logic [3:0] OP_PUSF = 4'h6;
  localparam logic [3:0] OP_REPL = 4'h7;
  localparam logic [3:0] OP_BIN  = 4'h8;
  localparam logic [3:0] OP_MULT = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_RST,
    S_RUN,
    S_STEP_WAIT,
    S_HALTED
  } seq_state_t;

  // Number of CPU execute cycles following the fetch cycle of an opcode.
  function automatic logic [1:0] exec_len(input logic [3:0] op);
    case (op)
      OP_NOOP, OP_OUTL, OP_OUTH:                          exec_len = 2'd1;
      OP_PUSH, OP_POP, OP_SWAP, OP_PUSF, OP_REPL, OP_BIN: exec_len = 2'd2;
      OP_MULT:                                            exec_len = 2'd3;
      default:                                            exec_len = 2'd1;
    endcase
  endfunction

  // Opcodes followed in memory by an operand nibble.
  function automatic logic has_operand(input logic [3:0] op);
    case (op)
      OP_PUSH, OP_PUSF, OP_REPL, OP_BIN: has_operand = 1'b1;
      default:                           has_operand = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_program_mem.sv
// Program nibble store: one synchronous write port, two asynchronous read
// ports (opcode and operand).
module seq_program_mem #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wdata,
  input  logic [ADDR_W-1:0] op_addr,
  output logic [3:0]        op_data,
  input  logic [ADDR_W-1:0] arg_addr,
  output logic [3:0]        arg_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign op_data  = mem[op_addr];
  assign arg_data = mem[arg_addr];

endmodule

// File: rtl/stack_sequencer.sv
// Program sequencer: replays stored nibbles into the stack CPU, locked to its
// fetch/execute slot rhythm, with CPU reset ownership and single-step support.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [3:0]        load_data,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic              cpu_rst,
  output logic [3:0]        cpu_inbits,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cyc_q, cyc_d;
  logic              step_pend_q, step_pend_d;

  logic              mem_we;
  logic [3:0]        op;
  logic [3:0]        opd;
  logic [1:0]        slot_e;
  logic              slot_end;
  logic              step_seen;

  assign mem_we = load_en && (state_q == S_IDLE || state_q == S_HALTED);

  seq_program_mem #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk      (clk),
    .we       (mem_we),
    .waddr    (load_addr),
    .wdata    (load_data),
    .op_addr  (pc_q),
    .op_data  (op),
    .arg_addr (pc_q + ADDR_W'(1)),
    .arg_data (opd)
  );

  // Only RUN issues program slots; STEP_WAIT and HALTED issue 2-cycle NOOP slots.
  assign slot_e    = (state_q == S_RUN) ? exec_len(op) : 2'd1;
  assign slot_end  = (cyc_q == slot_e);
  assign step_seen = step_pend_q || (step && state_q == S_STEP_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cyc_q       <= '0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cyc_q       <= cyc_d;
      step_pend_q <= step_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cyc_d       = cyc_q;
    step_pend_d = step_pend_q;
    cpu_rst     = 1'b0;
    cpu_inbits  = OP_NOOP;

    case (state_q)
      S_IDLE: begin
        cpu_rst     = 1'b1;
        cyc_d       = '0;
        step_pend_d = 1'b0;
        if (start) begin
          state_d = S_CPU_RST;
          pc_d    = '0;
        end
      end

      // Leaving CPU reset counts as the first slot boundary, so step_mode
      // already applies to the very first program slot.
      S_CPU_RST: begin
        cpu_rst     = 1'b1;
        pc_d        = '0;
        cyc_d       = '0;
        step_pend_d = 1'b0;
        state_d     = step_mode ? S_STEP_WAIT : S_RUN;
      end

      S_RUN: begin
        if (cyc_q == 2'd0) begin
          cpu_inbits = (op == OP_HALT) ? OP_NOOP : op;
        end else if (has_operand(op)) begin
          cpu_inbits = opd;
        end
        if (slot_end) begin
          cyc_d = '0;
          if (op == OP_HALT) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = pc_q + (has_operand(op) ? ADDR_W'(2) : ADDR_W'(1));
            state_d = step_mode ? S_STEP_WAIT : S_RUN;
          end
        end else begin
          cyc_d = cyc_q + 2'd1;
        end
      end

      S_STEP_WAIT: begin
        step_pend_d = step_seen;
        if (slot_end) begin
          cyc_d = '0;
          if (!step_mode || step_seen) begin
            state_d     = S_RUN;
            step_pend_d = 1'b0;
          end
        end else begin
          cyc_d = cyc_q + 2'd1;
        end
      end

      S_HALTED: begin
        cyc_d = slot_end ? 2'd0 : cyc_q + 2'd1;
        if (start) begin
          state_d = S_CPU_RST;
          pc_d    = '0;
          cyc_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cpu_rst = 1'b1;
      end
    endcase
  end

  assign pc     = pc_q;
  assign busy   = (state_q == S_RUN) || (state_q == S_STEP_WAIT);
  assign halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: the driver queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_stack_sequencer;

  localparam int unsigned ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [3:0]        load_data;
  logic              start;
  logic              step_mode;
  logic              step;
  logic              cpu_rst;
  logic [3:0]        cpu_inbits;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  stack_sequencer #(
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .step_mode  (step_mode),
    .step       (step),
    .cpu_rst    (cpu_rst),
    .cpu_inbits (cpu_inbits),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       cpu_rst;
    logic [3:0] bits;
    logic [3:0] pc;
    logic       busy;
    logic       halted;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  mon_e;
  string mon_n;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      n_tests++;
      if ({cpu_rst, cpu_inbits, pc, busy, halted} !== mon_e) begin
        n_fail++;
        $display("FAIL %s @%0t: got rst=%0b bits=%h pc=%0d busy=%0b halted=%0b, expected rst=%0b bits=%h pc=%0d busy=%0b halted=%0b",
                 mon_n, $time, cpu_rst, cpu_inbits, pc, busy, halted,
                 mon_e.cpu_rst, mon_e.bits, mon_e.pc, mon_e.busy, mon_e.halted);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of stimulus");
    $fatal(1);
  end

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic cyc(input string nm, input logic r, input logic [3:0] b,
                     input logic [3:0] p, input logic bs, input logic h);
    exp_t e;
    e.cpu_rst = r;
    e.bits    = b;
    e.pc      = p;
    e.busy    = bs;
    e.halted  = h;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic pslot(input string nm, input logic [3:0] op, input logic [3:0] opd,
                       input int len, input logic [3:0] p);
    cyc(nm, 1'b0, op, p, 1'b1, 1'b0);
    for (int i = 1; i < len; i++) cyc(nm, 1'b0, opd, p, 1'b1, 1'b0);
  endtask

  task automatic wslot(input string nm, input logic [3:0] p);
    cyc(nm, 1'b0, 4'h0, p, 1'b1, 1'b0);
    cyc(nm, 1'b0, 4'h0, p, 1'b1, 1'b0);
  endtask

  task automatic hcyc(input string nm, input logic [3:0] p);
    cyc(nm, 1'b0, 4'h0, p, 1'b0, 1'b1);
  endtask

  task automatic cpu_rst_cyc();
    cyc("cpu_rst", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  // PUSH 5, PUSH 3, BIN add, OUTL, HALT
  task automatic run_prog1(input string nm);
    pslot(nm, 4'h1, 4'h5, 3, 4'd0);
    pslot(nm, 4'h1, 4'h3, 3, 4'd2);
    pslot(nm, 4'h8, 4'h0, 3, 4'd4);
    pslot(nm, 4'h3, 4'h0, 2, 4'd6);
    pslot(nm, 4'h0, 4'h0, 2, 4'd7);
  endtask

  // PUSH 3, PUSH 4, MULT, OUTL, HALT
  task automatic run_prog2(input string nm);
    pslot(nm, 4'h1, 4'h3, 3, 4'd0);
    pslot(nm, 4'h1, 4'h4, 3, 4'd2);
    pslot(nm, 4'h9, 4'h0, 4, 4'd4);
    pslot(nm, 4'h3, 4'h0, 2, 4'd5);
    pslot(nm, 4'h0, 4'h0, 2, 4'd6);
  endtask

  logic [3:0] prog1 [8] = '{4'h1, 4'h5, 4'h1, 4'h3, 4'h8, 4'h0, 4'h3, 4'hF};
  logic [3:0] prog2 [7] = '{4'h1, 4'h3, 4'h1, 4'h4, 4'h9, 4'h3, 4'hF};

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; step_mode = 1'b0; step = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 1'b1, 4'h0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("idle", 1'b1, 4'h0, 4'd0, 1'b0, 1'b0);

    // Program 1; the final nibble is written in the same cycle as start.
    load_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load_addr = ADDR_W'(i);
      load_data = prog1[i];
      cyc("load_idle", 1'b1, 4'h0, 4'd0, 1'b0, 1'b0);
    end
    load_addr = 4'd7; load_data = prog1[7]; start = 1'b1;
    cyc("start_load", 1'b1, 4'h0, 4'd0, 1'b0, 1'b0);
    start = 1'b0;
    cpu_rst_cyc();
    // Attempted overwrite of address 0 and a stray start while busy.
    load_en = 1'b1; load_addr = 4'd0; load_data = 4'h9; start = 1'b1;
    pslot("p1_push5", 4'h1, 4'h5, 3, 4'd0);
    load_en = 1'b0; start = 1'b0;
    pslot("p1_push3", 4'h1, 4'h3, 3, 4'd2);
    pslot("p1_bin",   4'h8, 4'h0, 3, 4'd4);
    pslot("p1_outl",  4'h3, 4'h0, 2, 4'd6);
    pslot("p1_halt",  4'h0, 4'h0, 2, 4'd7);
    for (int i = 0; i < 4; i++) hcyc("p1_halted", 4'd7);

    // Rerun from HALTED: must be identical if address 0 kept its opcode.
    start = 1'b1;
    hcyc("p1_restart", 4'd7);
    start = 1'b0;
    cpu_rst_cyc();
    run_prog1("p1_rerun");
    hcyc("p1_rerun_halted", 4'd7);

    // Program 2 loaded while HALTED.
    load_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load_addr = ADDR_W'(i);
      load_data = prog2[i];
      hcyc("load_halted", 4'd7);
    end
    load_en = 1'b0; start = 1'b1;
    hcyc("p2_start", 4'd7);
    start = 1'b0;
    cpu_rst_cyc();
    run_prog2("p2_run");
    hcyc("p2_halted", 4'd6);

    // Reset in the middle of the MULT slot, then a clean rerun.
    start = 1'b1;
    hcyc("p2_restart", 4'd6);
    start = 1'b0;
    cpu_rst_cyc();
    pslot("mr_push3", 4'h1, 4'h3, 3, 4'd0);
    pslot("mr_push4", 4'h1, 4'h4, 3, 4'd2);
    cyc("mr_mult_f",  1'b0, 4'h9, 4'd4, 1'b1, 1'b0);
    cyc("mr_mult_e1", 1'b0, 4'h0, 4'd4, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("mr_mult_e2", 1'b0, 4'h0, 4'd4, 1'b1, 1'b0);
    rst = 1'b0;
    cyc("mr_idle", 1'b1, 4'h0, 4'd0, 1'b0, 1'b0);
    start = 1'b1;
    cyc("mr_start", 1'b1, 4'h0, 4'd0, 1'b0, 1'b0);
    start = 1'b0;
    cpu_rst_cyc();
    run_prog2("mr_rerun");
    hcyc("mr_halted", 4'd6);

    // Single-step mode.
    step_mode = 1'b1; start = 1'b1;
    hcyc("st_start", 4'd6);
    start = 1'b0;
    cpu_rst_cyc();
    wslot("st_wait0", 4'd0);
    wslot("st_wait0", 4'd0);
    step = 1'b1;
    cyc("st_step1", 1'b0, 4'h0, 4'd0, 1'b1, 1'b0);
    step = 1'b0;
    cyc("st_step1", 1'b0, 4'h0, 4'd0, 1'b1, 1'b0);
    pslot("st_push3", 4'h1, 4'h3, 3, 4'd0);
    wslot("st_wait2", 4'd2);
    wslot("st_wait2", 4'd2);
    step = 1'b1;
    cyc("st_step2", 1'b0, 4'h0, 4'd2, 1'b1, 1'b0);
    step = 1'b0;
    cyc("st_step2", 1'b0, 4'h0, 4'd2, 1'b1, 1'b0);
    pslot("st_push4", 4'h1, 4'h4, 3, 4'd2);
    wslot("st_wait4", 4'd4);
    step_mode = 1'b0;
    wslot("st_resume", 4'd4);
    pslot("st_mult", 4'h9, 4'h0, 4, 4'd4);
    pslot("st_outl", 4'h3, 4'h0, 2, 4'd5);
    pslot("st_halt", 4'h0, 4'h0, 2, 4'd6);
    hcyc("st_halted", 4'd6);

    // PUSH at the top address: operand from address 0, pc wraps to 1.
    load_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_addr = ADDR_W'(i);
      load_data = (i == 0) ? 4'h2 : ((i == 15) ? 4'h1 : 4'h0);
      hcyc("load_wrap", 4'd6);
    end
    load_en = 1'b0; start = 1'b1;
    hcyc("wr_start", 4'd6);
    start = 1'b0;
    cpu_rst_cyc();
    pslot("wr_pop", 4'h2, 4'h0, 3, 4'd0);
    for (int i = 1; i < 15; i++) pslot("wr_noop", 4'h0, 4'h0, 2, ADDR_W'(i));
    pslot("wr_push_top", 4'h1, 4'h2, 3, 4'd15);
    pslot("wr_wrapped", 4'h0, 4'h0, 2, 4'd1);
    rst = 1'b1;
    cyc("wr_rst", 1'b0, 4'h0, 4'd2, 1'b1, 1'b0);
    rst = 1'b0;
    cyc("wr_idle", 1'b1, 4'h0, 4'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never checked", exp_q.size());
    end
    if (n_tests < 100) begin
      n_fail++;
      $display("FAIL coverage: only %0d cycles checked", n_tests);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL");
    end
    $finish;
  end

endmodule
